bitwise_logic_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational 4-bit inverter.
- Performs one of eight bitwise operations on two WIDTH-bit operands and registers the result and flags.
- Uses a two-stage valid/ready pipeline so it can sit between the ALU operand latch and the result bus, with backpressure.
- Op 000 reproduces the legacy inverter function (result = ~a).

---
 rtl/bitwise_logic_pipe.sv | 134 +++++++++++++
 tb/tb_bitwise_logic_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_pipe.sv
// bitwise_logic_pipe
// Two-stage valid/ready pipeline that applies one of eight bitwise operations
// to two WIDTH-bit operands and registers the result together with its flags.
// Op 3'b000 reproduces the legacy inverter (result = ~a).
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   upstream presents a, b, op
//   in_ready   block can accept an operand set this cycle
//   a, b       WIDTH-bit operands (b unused by NOT and PASS)
//   op         operation select (000 NOT, 001 AND, 010 OR, 011 XOR,
//              100 NAND, 101 NOR, 110 XNOR, 111 PASS a)
//   out_valid  result and flags are valid
//   out_ready  downstream accepts the result this cycle
//   result     registered operation result
//   zero       result == 0
//   all_ones   result == all ones
//   parity     XOR-reduction of result (1 = odd number of ones)
module bitwise_logic_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             all_ones,
    output logic             parity
);

    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONE  = {WIDTH{1'b1}};

    // Odd-parity helper: 1 when v holds an odd number of ones.
    function automatic logic parity_of(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [2:0]       s1_op_r;
    logic             s2_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             all_ones_r;
    logic             parity_r;

    logic             s2_free_s;
    logic             advance_s;
    logic             accept_s;
    logic [WIDTH-1:0] op_res_s;

    // Handshake: stage 2 frees up when empty or being drained this cycle;
    // in_ready depends only on pipeline state and out_ready, never on in_valid.
    always_comb begin
        s2_free_s = !s2_valid_r || out_ready;
        advance_s = s1_valid_r && s2_free_s;
        in_ready  = !s1_valid_r || s2_free_s;
        accept_s  = in_valid && in_ready;
    end

    // Bitwise operation evaluated on the stage-1 operand registers.
    always_comb begin
        op_res_s = ~s1_a_r;
        case (s1_op_r)
            3'b000:  op_res_s = ~s1_a_r;
            3'b001:  op_res_s = s1_a_r & s1_b_r;
            3'b010:  op_res_s = s1_a_r | s1_b_r;
            3'b011:  op_res_s = s1_a_r ^ s1_b_r;
            3'b100:  op_res_s = ~(s1_a_r & s1_b_r);
            3'b101:  op_res_s = ~(s1_a_r | s1_b_r);
            3'b110:  op_res_s = ~(s1_a_r ^ s1_b_r);
            3'b111:  op_res_s = s1_a_r;
            default: op_res_s = ~s1_a_r;
        endcase
    end

    // Stage 1 operand register: loads on accept, empties when it advances
    // without a replacement; otherwise holds under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= ALL_ZERO;
            s1_b_r     <= ALL_ZERO;
            s1_op_r    <= 3'b000;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_a_r     <= a;
            s1_b_r     <= b;
            s1_op_r    <= op;
        end else if (advance_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2 result register: result and flags load together from the same
    // value so the flags always describe the registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            result_r   <= ALL_ZERO;
            zero_r     <= 1'b0;
            all_ones_r <= 1'b0;
            parity_r   <= 1'b0;
        end else if (advance_s) begin
            s2_valid_r <= 1'b1;
            result_r   <= op_res_s;
            zero_r     <= (op_res_s == ALL_ZERO);
            all_ones_r <= (op_res_s == ALL_ONE);
            parity_r   <= parity_of(op_res_s);
        end else if (out_ready) begin
            // Result is consumed; keep the last value on the bus.
            s2_valid_r <= 1'b0;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        out_valid = s2_valid_r;
        result    = result_r;
        zero      = zero_r;
        all_ones  = all_ones_r;
        parity    = parity_r;
    end

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
module tb_bitwise_logic_pipe;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       z;
        logic       ao;
        logic       p;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       iv4, ir4, ov4, or4, z4, ao4, p4;
    logic [3:0] a4, b4, res4;
    logic [2:0] op4;
    logic       iv8, ir8, ov8, or8, z8, ao8, p8;
    logic [7:0] a8, b8, res8;
    logic [2:0] op8;

    bitwise_logic_pipe #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .op(op4),
        .out_valid(ov4), .out_ready(or4), .result(res4), .zero(z4), .all_ones(ao4), .parity(p4)
    );

    bitwise_logic_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .op(op8),
        .out_valid(ov8), .out_ready(or8), .result(res8), .zero(z8), .all_ones(ao8), .parity(p8)
    );

    vec_t q4[$];
    vec_t q8[$];
    vec_t exp4, exp8;
    vec_t tbl[11];
    vec_t bp[4];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   acc4 = 0, got4 = 0, acc8 = 0, got8 = 0;
    logic hold4 = 1'b0, hold8 = 1'b0;
    logic [7:0] last4 = 8'h00, last8 = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Reference model: each op is a 2-input truth table indexed by {a_bit, b_bit}.
    function automatic logic [7:0] ref_res(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [3:0] tt[8];
        logic [3:0] t;
        logic [7:0] r;
        tt = '{4'b0011, 4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b1100};
        t  = tt[op];
        for (int i = 0; i < 8; i++) r[i] = t[{a[i], b[i]}];
        return r;
    endfunction

    function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int w);
        vec_t v;
        logic [7:0] mask;
        mask  = (w == 4) ? 8'h0F : 8'hFF;
        v.op  = op;
        v.a   = a & mask;
        v.b   = b & mask;
        v.res = ref_res(op, v.a, v.b) & mask;
        v.z   = (v.res == 8'h00);
        v.ao  = (v.res == mask);
        v.p   = ^v.res;
        return v;
    endfunction

    task automatic set4(input vec_t v);
        op4 = v.op; a4 = v.a[3:0]; b4 = v.b[3:0]; exp4 = v; iv4 = 1'b1;
    endtask

    // One cycle: inputs were driven before the call; sample handshakes 1 ns
    // later, then move to just past the next falling edge.
    task automatic tick();
        vec_t e;
        #1;
        if (hold4) begin
            check("hold4_valid", 32'(ov4), 32'd1);
            check("hold4_result", 32'(res4), 32'(last4[3:0]));
        end
        hold4 = ov4 && !or4;
        last4 = {4'h0, res4};
        if (ov4 && or4) begin
            if (q4.size() == 0) begin
                check("unexpected_out4", 32'(ov4), 32'd0);
            end else begin
                e = q4.pop_front();
                check("res4", 32'(res4), 32'(e.res[3:0]));
                check("zero4", 32'(z4), 32'(e.z));
                check("ones4", 32'(ao4), 32'(e.ao));
                check("par4", 32'(p4), 32'(e.p));
                got4++;
            end
        end
        if (iv4 && ir4) begin
            q4.push_back(exp4);
            acc4++;
        end
        if (hold8) begin
            check("hold8_valid", 32'(ov8), 32'd1);
            check("hold8_result", 32'(res8), 32'(last8));
        end
        hold8 = ov8 && !or8;
        last8 = res8;
        if (ov8 && or8) begin
            if (q8.size() == 0) begin
                check("unexpected_out8", 32'(ov8), 32'd0);
            end else begin
                e = q8.pop_front();
                check("res8", 32'(res8), 32'(e.res));
                check("zero8", 32'(z8), 32'(e.z));
                check("ones8", 32'(ao8), 32'(e.ao));
                check("par8", 32'(p8), 32'(e.p));
                got8++;
            end
        end
        if (iv8 && ir8) begin
            q8.push_back(exp8);
            acc8++;
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, gbase;
        tbl[0]  = '{3'd0, 8'hC, 8'hA, 8'h3, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{3'd1, 8'hC, 8'hA, 8'h8, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{3'd2, 8'hC, 8'hA, 8'hE, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{3'd3, 8'hC, 8'hA, 8'h6, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{3'd4, 8'hC, 8'hA, 8'h7, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{3'd5, 8'hC, 8'hA, 8'h1, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{3'd6, 8'hC, 8'hA, 8'h9, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{3'd7, 8'hC, 8'hA, 8'hC, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{3'd3, 8'h5, 8'h5, 8'h0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{3'd0, 8'h0, 8'h0, 8'hF, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{3'd7, 8'h1, 8'h0, 8'h1, 1'b0, 1'b0, 1'b1};
        bp[0] = mk(3'd1, 8'h6, 8'h3, 4);
        bp[1] = mk(3'd2, 8'h8, 8'h1, 4);
        bp[2] = mk(3'd6, 8'h9, 8'h5, 4);
        bp[3] = mk(3'd0, 8'h4, 8'h0, 4);

        rst = 1'b1;
        iv4 = 1'b0; a4 = 4'h0; b4 = 4'h0; op4 = 3'd0; or4 = 1'b1;
        iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; op8 = 3'd0; or8 = 1'b1;
        exp4 = mk(3'd0, 8'h0, 8'h0, 4);
        exp8 = mk(3'd0, 8'h0, 8'h0, 8);
        #12 rst = 1'b0;
        @(negedge clk);
        #1;

        // Reset state
        check("rst_out_valid", 32'(ov4), 32'd0);
        check("rst_result", 32'(res4), 32'd0);
        check("rst_flags", 32'({z4, ao4, p4}), 32'd0);
        check("rst_in_ready", 32'(ir4), 32'd1);

        // Legacy inverter with explicit latency
        set4(mk(3'd0, 8'hA, 8'h0, 4));
        tick();
        iv4 = 1'b0;
        check("lat_ov_early", 32'(ov4), 32'd0);
        tick();
        check("lat_ov", 32'(ov4), 32'd1);
        check("lat_res", 32'(res4), 32'h5);
        check("lat_flags", 32'({z4, ao4, p4}), 32'd0);
        tick();

        // Table sweep, back-to-back
        for (int i = 0; i < 11; i++) begin
            set4(tbl[i]);
            check("sweep_in_ready", 32'(ir4), 32'd1);
            tick();
        end
        iv4 = 1'b0;
        repeat (3) tick();
        check("sweep_drained", 32'(q4.size()), 32'd0);
        check("sweep_ov_low", 32'(ov4), 32'd0);

        // Backpressure: fill, hold 5 cycles, release
        base = acc4; gbase = got4; or4 = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (acc4 - base < 4) set4(bp[acc4 - base]);
            else iv4 = 1'b0;
            tick();
            if (c >= 2) begin
                check("bp_in_ready", 32'(ir4), 32'd0);
                check("bp_first_held", 32'(res4), 32'(bp[0].res[3:0]));
                check("bp_accepts", 32'(acc4 - base), 32'd2);
            end
        end
        or4 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (acc4 - base < 4) set4(bp[acc4 - base]);
            else iv4 = 1'b0;
            tick();
        end
        check("bp_delivered", 32'(got4 - gbase), 32'd4);
        check("bp_queue_empty", 32'(q4.size()), 32'd0);

        // Reset mid-stream with two sets in flight
        or4 = 1'b0; base = acc4;
        for (int c = 0; c < 2; c++) begin
            set4(bp[c + 1]);
            tick();
        end
        iv4 = 1'b0;
        check("mid_inflight", 32'(acc4 - base), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ov", 32'(ov4), 32'd0);
        check("mid_rst_res", 32'(res4), 32'd0);
        check("mid_rst_ready", 32'(ir4), 32'd1);
        q4.delete();
        hold4 = 1'b0;
        #1 rst = 1'b0;
        or4 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("mid_no_stale", 32'(ov4), 32'd0);
        end
        set4(mk(3'd5, 8'h2, 8'h4, 4));
        tick();
        iv4 = 1'b0;
        check("post_rst_early", 32'(ov4), 32'd0);
        tick();
        check("post_rst_ov", 32'(ov4), 32'd1);
        check("post_rst_res", 32'(res4), 32'h9);
        tick();

        // WIDTH=8 directed NAND
        op8 = 3'd4; a8 = 8'hF0; b8 = 8'hFF; iv8 = 1'b1;
        exp8 = mk(3'd4, 8'hF0, 8'hFF, 8);
        tick();
        iv8 = 1'b0;
        tick();
        check("w8_nand_res", 32'(res8), 32'h0F);
        check("w8_nand_par", 32'(p8), 32'd0);
        tick();

        // WIDTH=8 random traffic with random backpressure
        base = acc8; gbase = got8;
        for (int c = 0; c < 6000; c++) begin
            if (acc8 - base >= 1000) break;
            iv8 = ($urandom_range(0, 3) != 0);
            op8 = 3'($urandom_range(0, 7));
            a8  = 8'($urandom_range(0, 255));
            b8  = 8'($urandom_range(0, 255));
            exp8 = mk(op8, a8, b8, 8);
            or8 = ($urandom_range(0, 1) != 0);
            tick();
        end
        iv8 = 1'b0; or8 = 1'b1;
        repeat (4) tick();
        check("rand_accepted", 32'(acc8 - base), 32'd1000);
        check("rand_delivered", 32'(got8 - gbase), 32'd1000);
        check("rand_queue_empty", 32'(q8.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
